// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART blocks (uart_rx, uart_tx, uart_tx_buf).
//   - Default bit rate and system clock frequency.
//   - The transmit-pacing FSM state encoding.
//   - Elaboration-time helpers that derive BAUD_CNT and the inter-frame GAP.
//   The helpers are only ever called to set localparams, so they add no
//   runtime arithmetic.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEF_UART_BPS   = 9600;
  localparam int DEF_CLK_FREQ   = 50_000_000;
  localparam int DEF_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int calc_baud_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  // Clock cycles occupied by one complete serial frame.
  function automatic int calc_gap(input int frame_bits, input int baud_cnt);
    return frame_bits * baud_cnt;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO, DEPTH x WIDTH, DEPTH a power of two.
//   Read data is the current head (first-word fall-through), so the consumer
//   samples rdata in the same cycle it asserts pop.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (clears pointers and count)
//   push   in   write request; accepted when not full, or when full with an
//               accepted pop in the same cycle
//   pop    in   read request; ignored while empty
//   wdata  in   WIDTH  data to write
//   rdata  out  WIDTH  head entry
//   cnt    out  $clog2(DEPTH)+1  occupancy 0..DEPTH
//   full   out  cnt == DEPTH
//   empty  out  cnt == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // A pop frees the head slot in the same cycle, so a full FIFO may still
  // take a write when a read happens alongside it.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign rdata = mem[rd_ptr];

  // NOTE: the storage array has no reset; stale entries are unreachable
  // because the pointers and count are cleared, and leaving the RAM
  // unreset lets it map onto plain memory cells.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// -----------------------------------------------------------------------------
// uart_tx_buf
//   Elastic byte buffer between a UART receiver and a UART transmitter.
//   Incoming bytes are queued in a FIFO; a pacing FSM releases one byte per
//   serial frame time so the downstream transmitter is never restarted
//   while it is still shifting out the previous frame.
//
// Ports
//   sys_clk   in   single clock, rising edge
//   sys_rst   in   synchronous active-high reset
//   pi_data   in   8   byte from upstream receiver
//   pi_flag   in   one-cycle write strobe
//   po_data   out  8   byte to downstream transmitter, held between pulses
//   po_flag   out  one-cycle start strobe to downstream transmitter
//   fifo_cnt  out  $clog2(DEPTH)+1  current occupancy
//   full      out  occupancy == DEPTH
//   overflow  out  one-cycle pulse, the cycle after a dropped write
// -----------------------------------------------------------------------------
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int UART_BPS   = DEF_UART_BPS,
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int DEPTH      = 16,
  parameter int FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [7:0]             pi_data,
  input  logic                   pi_flag,
  output logic [7:0]             po_data,
  output logic                   po_flag,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   full,
  output logic                   overflow
);

  localparam int BAUD_CNT = calc_baud_cnt(CLK_FREQ, UART_BPS);
  localparam int GAP      = calc_gap(FRAME_BITS, BAUD_CNT);
  localparam int GW       = $clog2(GAP) + 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  tx_state_e     state_q;
  tx_state_e     state_d;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;
  logic          pop;
  logic          empty;
  logic [7:0]    head;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (pi_flag),
    .pop   (pop),
    .wdata (pi_data),
    .rdata (head),
    .cnt   (fifo_cnt),
    .full  (full),
    .empty (empty)
  );

  // NOTE: every signal driven here gets a default before the case, so no
  // path through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_SEND;
        end
      end
      // SEND is only ever entered with the FIFO non-empty, so the pop here
      // always removes a real byte.
      ST_SEND: begin
        pop     = 1'b1;
        gap_d   = GAP_LOAD;
        state_d = ST_WAIT;
      end
      // GAP cycles in WAIT plus the SEND cycle give GAP+1 cycles between
      // successive po_flag pulses.
      ST_WAIT: begin
        if (gap_q == '0) begin
          state_d = empty ? ST_IDLE : ST_SEND;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // The popped byte and its strobe are registered together, so po_data is
  // valid in exactly the cycle po_flag is high and is held afterwards.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      po_data  <= 8'h00;
      po_flag  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      po_flag  <= pop;
      overflow <= pi_flag && full && !pop;
      if (pop) begin
        po_data <= head;
      end
    end
  end

endmodule
